forward_hazard_unit: RTL and testbench

Parametrised operand-forwarding and load-use hazard unit for the RV32I pipeline, sitting between the ID/EX register and the ALU operand muxes. It selects each EX operand from the register file, the MEM-stage ALU result, the WB write data, or a per-operand hold register. It generates a load-use stall of configurable length and keeps late WB results that would otherwise be lost while EX is frozen.

---
 rtl/rv_pipe_pkg.sv | 16 +
 rtl/forward_lane.sv | 81 ++++++++
 rtl/forward_hazard_unit.sv | 109 ++++++++++
 tb/tb_forward_hazard_unit.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared RV32I pipeline types and default widths.
// Holds the forwarding-source encoding used by the EX operand muxes.
package rv_pipe_pkg;

    localparam int REG_DATA_WIDTH_DEF     = 32;
    localparam int REGFILE_ADDR_WIDTH_DEF = 5;
    localparam int LOAD_LATENCY_DEF       = 1;

    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10,
        FWD_HOLD = 2'b11
    } fwd_sel_t;

endpackage

// File: rtl/forward_lane.sv
// One EX operand lane: MEM/WB match logic, source priority mux and the
// hold register that keeps a WB result alive while EX is frozen.
// Ports: clk/rst; rs_* = EX source; mem_*/wb_* = producer stages;
//   frozen = EX held this cycle; flush = squash EX;
//   forward/operand = selected source and value;
//   mem_load_match = operand waits on the load now in MEM.
import rv_pipe_pkg::*;

module forward_lane #(
    parameter int DW = REG_DATA_WIDTH_DEF,
    parameter int AW = REGFILE_ADDR_WIDTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rs_address,
    input  logic          rs_used,
    input  logic [DW-1:0] rs_data,
    input  logic          mem_wr_en,
    input  logic          mem_is_load,
    input  logic [AW-1:0] mem_rd_address,
    input  logic [DW-1:0] mem_alu_result,
    input  logic          wb_wr_en,
    input  logic [AW-1:0] wb_rd_address,
    input  logic [DW-1:0] wb_wr_data,
    input  logic          frozen,
    input  logic          flush,
    output fwd_sel_t      forward,
    output logic [DW-1:0] operand,
    output logic          mem_load_match
);

    logic          rs_live;
    logic          mem_match;
    logic          wb_match;
    logic          hold_valid;
    logic [DW-1:0] hold_data;

    // x0 never matches: a nonzero Rs that is actually read is required.
    assign rs_live   = rs_used && (rs_address != '0);
    assign mem_match = rs_live && mem_wr_en
                       && (mem_rd_address == rs_address);
    assign wb_match  = rs_live && wb_wr_en
                       && (wb_rd_address == rs_address);

    assign mem_load_match = mem_match && mem_is_load;

    always_comb begin
        forward = FWD_RF;
        operand = rs_data;
        if (rs_address == '0) begin
            forward = FWD_RF;
            operand = rs_data;
        end else if (mem_match && !mem_is_load) begin
            forward = FWD_MEM;
            operand = mem_alu_result;
        end else if (wb_match) begin
            forward = FWD_WB;
            operand = wb_wr_data;
        end else if (hold_valid) begin
            forward = FWD_HOLD;
            operand = hold_data;
        end
    end

    // A WB result seen while frozen would leave the pipe before EX
    // consumes it; newest capture wins, cleared once EX moves on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (flush) begin
            hold_valid <= 1'b0;
        end else if (frozen && wb_match) begin
            hold_valid <= 1'b1;
            hold_data  <= wb_wr_data;
        end else if (!frozen) begin
            hold_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// EX operand forwarding plus load-use stall generation.
// Ports: EX_Rs*/MEM_*/WB_* pipeline taps; ext_stall/flush controls;
//   ForwardA/B + EX_op1/2 selected operands; stall holds IF/ID/EX.
import rv_pipe_pkg::*;

module forward_hazard_unit #(
    parameter int REG_DATA_WIDTH     = REG_DATA_WIDTH_DEF,
    parameter int REGFILE_ADDR_WIDTH = REGFILE_ADDR_WIDTH_DEF,
    parameter int LOAD_LATENCY       = LOAD_LATENCY_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [REGFILE_ADDR_WIDTH-1:0] EX_Rs1_address,
    input  logic [REGFILE_ADDR_WIDTH-1:0] EX_Rs2_address,
    input  logic                          EX_Rs1_used,
    input  logic                          EX_Rs2_used,
    input  logic [REG_DATA_WIDTH-1:0]     EX_Rs1_data,
    input  logic [REG_DATA_WIDTH-1:0]     EX_Rs2_data,
    input  logic                          MEM_RegFile_wr_en,
    input  logic                          MEM_is_load,
    input  logic [REGFILE_ADDR_WIDTH-1:0] MEM_Rd_address,
    input  logic [REG_DATA_WIDTH-1:0]     MEM_alu_result,
    input  logic                          WB_RegFile_wr_en,
    input  logic [REGFILE_ADDR_WIDTH-1:0] WB_Rd_address,
    input  logic [REG_DATA_WIDTH-1:0]     WB_wr_data,
    input  logic                          ext_stall,
    input  logic                          flush,
    output logic [1:0]                    ForwardA,
    output logic [1:0]                    ForwardB,
    output logic [REG_DATA_WIDTH-1:0]     EX_op1,
    output logic [REG_DATA_WIDTH-1:0]     EX_op2,
    output logic                          stall
);

    localparam int CW = $clog2(LOAD_LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LOAD_LATENCY - 1);

    logic [CW-1:0] cnt;
    logic          hazard_now;
    logic          frozen;
    logic          load_match_a;
    logic          load_match_b;
    fwd_sel_t      fwd_a;
    fwd_sel_t      fwd_b;

    assign hazard_now = (cnt == '0) && MEM_is_load
                        && (load_match_a || load_match_b);
    assign stall      = hazard_now || (cnt != '0);
    assign frozen     = stall || ext_stall;
    assign ForwardA   = fwd_a;
    assign ForwardB   = fwd_b;

    forward_lane #(.DW(REG_DATA_WIDTH), .AW(REGFILE_ADDR_WIDTH)) u_lane_a (
        .clk            (clk),
        .rst            (rst),
        .rs_address     (EX_Rs1_address),
        .rs_used        (EX_Rs1_used),
        .rs_data        (EX_Rs1_data),
        .mem_wr_en      (MEM_RegFile_wr_en),
        .mem_is_load    (MEM_is_load),
        .mem_rd_address (MEM_Rd_address),
        .mem_alu_result (MEM_alu_result),
        .wb_wr_en       (WB_RegFile_wr_en),
        .wb_rd_address  (WB_Rd_address),
        .wb_wr_data     (WB_wr_data),
        .frozen         (frozen),
        .flush          (flush),
        .forward        (fwd_a),
        .operand        (EX_op1),
        .mem_load_match (load_match_a)
    );

    forward_lane #(.DW(REG_DATA_WIDTH), .AW(REGFILE_ADDR_WIDTH)) u_lane_b (
        .clk            (clk),
        .rst            (rst),
        .rs_address     (EX_Rs2_address),
        .rs_used        (EX_Rs2_used),
        .rs_data        (EX_Rs2_data),
        .mem_wr_en      (MEM_RegFile_wr_en),
        .mem_is_load    (MEM_is_load),
        .mem_rd_address (MEM_Rd_address),
        .mem_alu_result (MEM_alu_result),
        .wb_wr_en       (WB_RegFile_wr_en),
        .wb_rd_address  (WB_Rd_address),
        .wb_wr_data     (WB_wr_data),
        .frozen         (frozen),
        .flush          (flush),
        .forward        (fwd_b),
        .operand        (EX_op2),
        .mem_load_match (load_match_b)
    );

    // cnt counts remaining stall cycles after the hazard cycle itself;
    // external stalls freeze it so only our own bubbles are counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (!ext_stall) begin
            if (hazard_now) begin
                cnt <= CNT_LOAD;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Self-checking bench for forward_hazard_unit at LOAD_LATENCY 1 and 3.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_forward_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1, rs2, mem_rd, wb_rd;
    logic        u1s, u2s;
    logic [31:0] d1, d2, mem_res, wb_data;
    logic        mem_we, mem_ld, wb_we, ext, fl;

    logic [1:0]  fa [2];
    logic [1:0]  fb [2];
    logic [31:0] o1 [2];
    logic [31:0] o2 [2];
    logic        st [2];

    int checks = 0;
    int failures = 0;

    // Model state: stall cycles still owed after the current one,
    // and per-operand kept WB values.
    int          rem [2];
    logic        hv  [2][2];
    logic [31:0] hd  [2][2];

    always #5 clk = ~clk;

    forward_hazard_unit #(.LOAD_LATENCY(1)) u1 (
        .clk(clk), .rst(rst),
        .EX_Rs1_address(rs1), .EX_Rs2_address(rs2),
        .EX_Rs1_used(u1s), .EX_Rs2_used(u2s),
        .EX_Rs1_data(d1), .EX_Rs2_data(d2),
        .MEM_RegFile_wr_en(mem_we), .MEM_is_load(mem_ld),
        .MEM_Rd_address(mem_rd), .MEM_alu_result(mem_res),
        .WB_RegFile_wr_en(wb_we), .WB_Rd_address(wb_rd),
        .WB_wr_data(wb_data), .ext_stall(ext), .flush(fl),
        .ForwardA(fa[0]), .ForwardB(fb[0]),
        .EX_op1(o1[0]), .EX_op2(o2[0]), .stall(st[0])
    );

    forward_hazard_unit #(.LOAD_LATENCY(3)) u3 (
        .clk(clk), .rst(rst),
        .EX_Rs1_address(rs1), .EX_Rs2_address(rs2),
        .EX_Rs1_used(u1s), .EX_Rs2_used(u2s),
        .EX_Rs1_data(d1), .EX_Rs2_data(d2),
        .MEM_RegFile_wr_en(mem_we), .MEM_is_load(mem_ld),
        .MEM_Rd_address(mem_rd), .MEM_alu_result(mem_res),
        .WB_RegFile_wr_en(wb_we), .WB_Rd_address(wb_rd),
        .WB_wr_data(wb_data), .ext_stall(ext), .flush(fl),
        .ForwardA(fa[1]), .ForwardB(fb[1]),
        .EX_op1(o1[1]), .EX_op2(o2[1]), .stall(st[1])
    );

    function automatic int lat(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [4:0] m_rs(int op);
        return (op == 0) ? rs1 : rs2;
    endfunction

    function automatic logic m_used(int op);
        return (op == 0) ? u1s : u2s;
    endfunction

    function automatic logic m_wbm(int op);
        return m_used(op) && m_rs(op) != 0 && wb_we && wb_rd == m_rs(op);
    endfunction

    function automatic logic m_memm(int op);
        return m_used(op) && m_rs(op) != 0 && mem_we && mem_rd == m_rs(op);
    endfunction

    function automatic logic [1:0] m_sel(int k, int op);
        if (m_rs(op) == 0) return 2'b00;
        if (m_memm(op) && !mem_ld) return 2'b10;
        if (m_wbm(op)) return 2'b01;
        if (hv[k][op]) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [31:0] m_val(int k, int op);
        case (m_sel(k, op))
            2'b10:   return mem_res;
            2'b01:   return wb_data;
            2'b11:   return hd[k][op];
            default: return (op == 0) ? d1 : d2;
        endcase
    endfunction

    function automatic logic m_haz(int k);
        return rem[k] == 0 && mem_ld && (m_memm(0) || m_memm(1));
    endfunction

    function automatic logic m_stall(int k);
        return m_haz(k) || rem[k] != 0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            rem[k] = 0;
            for (int op = 0; op < 2; op++) begin
                hv[k][op] = 1'b0;
                hd[k][op] = '0;
            end
        end
    endtask

    task automatic idle();
        rs1 = 0; rs2 = 0; u1s = 0; u2s = 0;
        d1 = 32'h1111_0001; d2 = 32'h2222_0002;
        mem_we = 0; mem_ld = 0; mem_rd = 0; mem_res = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0; ext = 0; fl = 0;
    endtask

    // Rising edge: advance the model with the inputs still stable,
    // then return at the falling edge ready for new stimulus.
    task automatic tick();
        logic s, h;
        @(posedge clk);
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                s = m_stall(k);
                h = m_haz(k);
                if (fl) begin
                    rem[k] = 0;
                    hv[k][0] = 0;
                    hv[k][1] = 0;
                end else begin
                    if (!ext) begin
                        if (h) rem[k] = lat(k) - 1;
                        else if (rem[k] != 0) rem[k] = rem[k] - 1;
                    end
                    for (int op = 0; op < 2; op++) begin
                        if ((s || ext) && m_wbm(op)) begin
                            hv[k][op] = 1;
                            hd[k][op] = wb_data;
                        end else if (!s && !ext) begin
                            hv[k][op] = 0;
                        end
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic reset_dut();
        idle();
        rst = 1;
        model_clear();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        model_clear();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (st[k] !== 1'b0 || fa[k] !== 2'b00 || fb[k] !== 2'b00) begin
                failures++;
                $display("FAIL reset[%0d] stall=%0b fa=%b fb=%b exp 0/00/00",
                         k, st[k], fa[k], fb[k]);
            end
            checks++;
            if (o1[k] !== 32'h1111_0001) begin
                failures++;
                $display("FAIL reset_op1[%0d] got=%h exp=11110001", k, o1[k]);
            end
        end
        tick();
        rst = 0;
    endtask

    task automatic test_alu_alu();
        reset_dut();
        mem_we = 1; mem_rd = 5; mem_res = 32'h1234;
        rs1 = 5; u1s = 1;
        #1;
        checks++;
        if (fa[0] !== 2'b10 || o1[0] !== 32'h1234 || st[0] !== 1'b0) begin
            failures++;
            $display("FAIL alu_alu fa=%b op1=%h stall=%0b exp 10/1234/0",
                     fa[0], o1[0], st[0]);
        end
        mem_rd = 0;
        #1;
        checks++;
        if (fa[0] !== 2'b00 || o1[0] !== 32'h1111_0001) begin
            failures++;
            $display("FAIL alu_rd0 fa=%b op1=%h exp 00/11110001", fa[0], o1[0]);
        end
    endtask

    task automatic test_load_use();
        reset_dut();
        mem_we = 1; mem_ld = 1; mem_rd = 7; rs2 = 7; u2s = 1;
        #1;
        checks++;
        if (st[0] !== 1'b1) begin
            failures++;
            $display("FAIL load_use_stall got=%0b exp=1", st[0]);
        end
        tick();
        mem_we = 0; mem_ld = 0; mem_rd = 0;
        wb_we = 1; wb_rd = 7; wb_data = 32'hCAFE;
        #1;
        checks++;
        if (st[0] !== 1'b0 || fb[0] !== 2'b01 || o2[0] !== 32'hCAFE) begin
            failures++;
            $display("FAIL load_use_wb stall=%0b fb=%b op2=%h exp 0/01/cafe",
                     st[0], fb[0], o2[0]);
        end
        reset_dut();
        mem_we = 1; mem_ld = 1; mem_rd = 7; rs2 = 7; u2s = 0;
        #1;
        checks++;
        if (st[0] !== 1'b0 || st[1] !== 1'b0) begin
            failures++;
            $display("FAIL load_unused stall=%0b/%0b exp 0/0", st[0], st[1]);
        end
    endtask

    task automatic test_lat3_ext();
        logic exp_st [6] = '{1, 1, 1, 1, 1, 0};
        logic ex_pat [6] = '{0, 1, 1, 0, 0, 0};
        int   n = 0;
        reset_dut();
        rs2 = 7; u2s = 1;
        for (int c = 0; c < 6; c++) begin
            mem_we = (c == 0); mem_ld = (c == 0); mem_rd = (c == 0) ? 5'd7 : 5'd0;
            ext = ex_pat[c];
            #1;
            if (st[1] === 1'b1) n++;
            checks++;
            if (st[1] !== exp_st[c]) begin
                failures++;
                $display("FAIL lat3_ext cyc%0d stall=%0b exp=%0b", c, st[1], exp_st[c]);
            end
            tick();
        end
        checks++;
        if (n != 5) begin
            failures++;
            $display("FAIL lat3_len got=%0d exp=5", n);
        end
    endtask

    task automatic test_hold();
        reset_dut();
        ext = 1; wb_we = 1; wb_rd = 3; wb_data = 32'hAA; rs1 = 3; u1s = 1;
        d1 = 32'h11;
        #1;
        checks++;
        if (fa[0] !== 2'b01 || o1[0] !== 32'hAA) begin
            failures++;
            $display("FAIL hold_wb fa=%b op1=%h exp 01/aa", fa[0], o1[0]);
        end
        tick();
        wb_we = 0; ext = 0;
        #1;
        checks++;
        if (fa[0] !== 2'b11 || o1[0] !== 32'hAA) begin
            failures++;
            $display("FAIL hold_use fa=%b op1=%h exp 11/aa", fa[0], o1[0]);
        end
        tick();
        #1;
        checks++;
        if (fa[0] !== 2'b00 || o1[0] !== 32'h11) begin
            failures++;
            $display("FAIL hold_clear fa=%b op1=%h exp 00/11", fa[0], o1[0]);
        end
    endtask

    task automatic test_flush();
        reset_dut();
        mem_we = 1; mem_ld = 1; mem_rd = 7; rs2 = 7; u2s = 1;
        wb_we = 1; wb_rd = 3; wb_data = 32'h55; rs1 = 3; u1s = 1;
        tick();
        mem_we = 0; mem_ld = 0; mem_rd = 0; wb_we = 0;
        #1;
        checks++;
        if (st[1] !== 1'b1 || fa[1] !== 2'b11) begin
            failures++;
            $display("FAIL flush_pre stall=%0b fa=%b exp 1/11", st[1], fa[1]);
        end
        fl = 1;
        tick();
        fl = 0;
        #1;
        checks++;
        if (st[1] !== 1'b0 || fa[1] !== 2'b00 || fb[1] !== 2'b00) begin
            failures++;
            $display("FAIL flush_post stall=%0b fa=%b fb=%b exp 0/00/00",
                     st[1], fa[1], fb[1]);
        end
    endtask

    task automatic test_reset_mid_stall();
        reset_dut();
        mem_we = 1; mem_ld = 1; mem_rd = 7; rs2 = 7; u2s = 1;
        wb_we = 1; wb_rd = 3; wb_data = 32'h77; rs1 = 3; u1s = 1;
        tick();
        mem_we = 0; mem_ld = 0; mem_rd = 0; wb_we = 0;
        #1;
        checks++;
        if (st[1] !== 1'b1 || fa[1] !== 2'b11) begin
            failures++;
            $display("FAIL rst_mid_pre stall=%0b fa=%b exp 1/11", st[1], fa[1]);
        end
        rst = 1;
        model_clear();
        #1;
        checks++;
        if (st[1] !== 1'b0 || fa[1] !== 2'b00) begin
            failures++;
            $display("FAIL rst_mid_clear stall=%0b fa=%b exp 0/00", st[1], fa[1]);
        end
        mem_we = 1; mem_ld = 1; mem_rd = 7;
        #1;
        checks++;
        if (st[1] !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_haz stall=%0b exp 1", st[1]);
        end
        tick();
        #1;
        checks++;
        if (st[1] !== 1'b1) begin
            failures++;
            $display("FAIL rst_edge_noupd stall=%0b exp 1", st[1]);
        end
        reset_dut();
    endtask

    task automatic test_random();
        reset_dut();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            u1s = ($urandom_range(0, 4) != 0);
            u2s = ($urandom_range(0, 4) != 0);
            d1 = $urandom; d2 = $urandom;
            mem_we = $urandom_range(0, 1);
            mem_ld = ($urandom_range(0, 2) == 0);
            mem_rd = 5'($urandom_range(0, 3));
            mem_res = $urandom;
            wb_we = $urandom_range(0, 1);
            wb_rd = 5'($urandom_range(0, 3));
            wb_data = $urandom;
            ext = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 15) == 0);
            if (rst) model_clear();
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (st[k] !== m_stall(k) || fa[k] !== m_sel(k, 0)
                    || fb[k] !== m_sel(k, 1) || o1[k] !== m_val(k, 0)
                    || o2[k] !== m_val(k, 1)) begin
                    failures++;
                    $display("FAIL rand[%0d] c=%0d st=%0b/%0b fa=%b/%b fb=%b/%b op1=%h/%h op2=%h/%h",
                             k, c, st[k], m_stall(k), fa[k], m_sel(k, 0),
                             fb[k], m_sel(k, 1), o1[k], m_val(k, 0),
                             o2[k], m_val(k, 1));
                end
            end
            tick();
        end
        rst = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        model_clear();
        @(negedge clk);
        test_reset();
        test_alu_alu();
        test_load_use();
        test_lat3_ext();
        test_hold();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
